kv_wb_initiator: RTL

- Wishbone initiator that drives the key-value store responder (keyvalue_3 style: 128-bit data, 64-bit address, 64-bit key).
- Accepts put/get commands from a local valid/ready port, runs one Wishbone classic cycle per command, and returns the read data or a completion/error status on a response valid/ready port.
- Sits between a user-area controller (or LA-driven test logic) and the key-value store's Wishbone slave port.
- One outstanding transaction at a time.

---
 rtl/kv_pkg.sv | 33 +++
 rtl/kv_watchdog.sv | 52 +++++
 rtl/kv_wb_initiator.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/kv_pkg.sv
// -----------------------------------------------------------------------------
// kv_pkg
// Shared types and constants for the key-value store Wishbone initiator.
//   kv_state_e      : initiator FSM states (IDLE, REQ, RESP)
//   OP_PUT / OP_GET : values of cmd_we for write and read commands
//   KV_*_W          : default bus widths of the keyvalue_3 style responder
//   kv_cnt_width()  : watchdog counter width for a given TIMEOUT (8 or 16 bits)
// -----------------------------------------------------------------------------
package kv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } kv_state_e;

    localparam logic OP_PUT = 1'b1;
    localparam logic OP_GET = 1'b0;

    localparam int KV_DATA_W = 128;
    localparam int KV_ADR_W  = 64;
    localparam int KV_KEY_W  = 64;

    // Smallest of 8 or 16 bits that can hold the timeout count.
    function automatic int kv_cnt_width(input int timeout);
        if (timeout < 256) begin
            return 8;
        end else begin
            return 16;
        end
    endfunction

endpackage

// File: rtl/kv_watchdog.sv
// -----------------------------------------------------------------------------
// kv_watchdog
// ACK watchdog for the Wishbone initiator. Only instantiated when the
// initiator is built with KV_INIT_TIMEOUT_EN defined.
//   sys_clk  in  clock
//   sys_rst  in  synchronous active-high reset
//   clear    in  restart the count (asserted on the edge that enters REQ)
//   enable   in  count this cycle (REQ without ACK_i)
//   expired  out high in the REQ cycle whose edge brings the count to TIMEOUT
// -----------------------------------------------------------------------------
module kv_watchdog
    import kv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = kv_cnt_width(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count reaches TIMEOUT on the edge that ends this cycle.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next count: clear on REQ entry, advance on idle REQ cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kv_wb_initiator.sv
// -----------------------------------------------------------------------------
// kv_wb_initiator
// Wishbone classic initiator for the key-value store responder. Takes one
// put/get command at a time from a valid/ready port, runs one Wishbone cycle,
// and presents read data (or zero for a put) on a valid/ready response port.
//
// Build option: KV_INIT_TIMEOUT_EN -- when defined, a kv_watchdog aborts a
// cycle that sees no ACK_i within TIMEOUT cycles and reports rsp_err=1.
// Without it REQ waits for ACK_i indefinitely and rsp_err stays 0.
//
// Ports
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_we/sel/adr/key/dat    command fields (cmd_we: 1=put, 0=get)
//   rsp_valid/rsp_ready       response handshake
//   rsp_dat, rsp_err          read data (0 for puts), timeout flag
//   STB_o, CYC_o, WE_o, SEL_o, ADR_o, KEY_o, DAT_o   Wishbone request
//   DAT_i, ACK_i              Wishbone read data and acknowledge
// All outputs are registered.
// -----------------------------------------------------------------------------
module kv_wb_initiator
    import kv_pkg::*;
#(
    parameter int DATA_W  = KV_DATA_W,
    parameter int ADR_W   = KV_ADR_W,
    parameter int KEY_W   = KV_KEY_W,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [3:0]        cmd_sel,
    input  logic [ADR_W-1:0]  cmd_adr,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic [DATA_W-1:0] cmd_dat,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_dat,
    output logic              rsp_err,
    output logic              STB_o,
    output logic              CYC_o,
    output logic              WE_o,
    output logic [3:0]        SEL_o,
    output logic [ADR_W-1:0]  ADR_o,
    output logic [KEY_W-1:0]  KEY_o,
    output logic [DATA_W-1:0] DAT_o,
    input  logic [DATA_W-1:0] DAT_i,
    input  logic              ACK_i
);

    kv_state_e         state_q,     state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              stb_q,       stb_d;
    logic              cyc_q,       cyc_d;
    logic              we_q,        we_d;
    logic [3:0]        sel_q,       sel_d;
    logic [ADR_W-1:0]  adr_q,       adr_d;
    logic [KEY_W-1:0]  key_q,       key_d;
    logic [DATA_W-1:0] dat_q,       dat_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_dat_q,   rsp_dat_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              wd_expired_s;

`ifdef KV_INIT_TIMEOUT_EN
    logic wd_clear_s;
    logic wd_enable_s;

    // Restart on the accept edge; count only REQ cycles that lack ACK_i.
    assign wd_clear_s  = (state_q == IDLE) && cmd_valid;
    assign wd_enable_s = (state_q == REQ) && !ACK_i;

    kv_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );
`else
    // No watchdog: never expires. TIMEOUT is always non-negative, so this
    // folds to 0 while keeping the parameter referenced in this build.
    assign wd_expired_s = (TIMEOUT < 0);
`endif

    assign cmd_ready = cmd_ready_q;
    assign STB_o     = stb_q;
    assign CYC_o     = cyc_q;
    assign WE_o      = we_q;
    assign SEL_o     = sel_q;
    assign ADR_o     = adr_q;
    assign KEY_o     = key_q;
    assign DAT_o     = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and next-output logic of the command/response FSM.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        stb_d       = stb_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        key_d       = key_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Capture the command; request fields then stay frozen
                    // for the whole Wishbone cycle.
                    state_d     = REQ;
                    cmd_ready_d = 1'b0;
                    stb_d       = 1'b1;
                    cyc_d       = 1'b1;
                    we_d        = cmd_we;
                    sel_d       = cmd_sel;
                    adr_d       = cmd_adr;
                    key_d       = cmd_key;
                    dat_d       = cmd_dat;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end

            REQ: begin
                if (ACK_i) begin
                    // ACK has priority over a watchdog expiring on this edge.
                    state_d     = RESP;
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    if (we_q == OP_PUT) begin
                        rsp_dat_d = {DATA_W{1'b0}};
                    end else begin
                        rsp_dat_d = DAT_i;
                    end
                end else if (wd_expired_s) begin
                    state_d     = RESP;
                    stb_d       = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = {DATA_W{1'b0}};
                end else begin
                    stb_d = 1'b1;
                    cyc_d = 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                stb_d       = 1'b0;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= {ADR_W{1'b0}};
            key_q       <= {KEY_W{1'b0}};
            dat_q       <= {DATA_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            stb_q       <= stb_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            key_q       <= key_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
